spi_regbank_peripheral: RTL and testbench
=========================================

Name: spi_regbank_peripheral

Overview:
- Parametrised SPI mode-0 peripheral: holds a bank of NUM_REGS control registers, each DATA_W bits wide.
- Next generation of the fixed 5x8-bit write-only SPI register block. Adds configurable address/data/register-count widths, read-back on CIPO, a write strobe, and frame-length error detection.
- Sits between the chip pins and the PWM/output-enable logic. All SPI pins are asynchronous and are synchronised into clk.

Parameters:
- ADDR_W, 7, address field width in bits.
- DATA_W, 8, register and data field width in bits.
- NUM_REGS, 5, number of implemented registers, at addresses 0..NUM_REGS-1; must be ≤ 2^ADDR_W.
- Derived, not a parameter: FRAME_W = 1+ADDR_W+DATA_W (default 16).

Ports:
- clk  in  1  system clock; only clock in the block.
- rst_n  in  1  reset; synchronous, active-low.
- SCLK  in  1  SPI clock, asynchronous, mode 0 (idle low, sample on rise).
- COPI  in  1  controller-out data, MSB first.
- nCS  in  1  chip select, active low.
- CIPO  out  1  peripheral-out read data, registered.
- CIPO_oe  out  1  high while CIPO is being driven.
- regs_out  out  NUM_REGS*DATA_W  flat register bank; reg k is at [k*DATA_W +: DATA_W].
- wr_strobe  out  1  one-clk pulse on each committed write.
- wr_addr  out  ADDR_W  address of the last committed write; held between writes.
- frame_err  out  1  one-clk pulse when a frame ends with a bad bit count.
- busy  out  1  synchronised nCS is low.

Behaviour:
- Reset (rst_n low at a clk edge) clears state to:
  - regs_out, wr_addr, counters, shift registers: 0.
  - CIPO, CIPO_oe, wr_strobe, frame_err: 0.
  - Synchronisers: idle (nCS sync = all 1, SCLK/COPI sync = 0).
  - Reset mid-frame discards the frame. Activity after release waits for a fresh nCS fall.
- Synchronisation:
  - 2-flop synchroniser plus 1 history flop on SCLK, nCS and COPI; all three get equal delay.
  - Edges are detected from the last two stages.
  - COPI is sampled from the stage aligned with the SCLK edge detector.
- Frame format, MSB first: bit 0 = R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
- States: IDLE, SHIFT, READOUT, COMMIT.
  - IDLE: on sync nCS fall → SHIFT; clear bit_cnt and shift register.
  - SHIFT: each sync SCLK rise shifts in COPI and increments bit_cnt, saturating at FRAME_W+1.
  - When bit_cnt reaches 1+ADDR_W with R/W=0 → READOUT. Load tx shift with regs[addr], or 0 if addr ≥ NUM_REGS.
  - READOUT: each sync SCLK fall while bit_cnt < FRAME_W: CIPO <= tx[MSB], tx <<= 1, CIPO_oe = 1. Rising edges continue counting COPI (ignored).
  - Sync nCS rise from SHIFT/READOUT → COMMIT (1 clk) → IDLE.
- COMMIT rules:
  - bit_cnt == FRAME_W, write, addr < NUM_REGS: update reg, wr_strobe = 1, wr_addr = addr.
  - bit_cnt == FRAME_W, write, addr ≥ NUM_REGS: silently dropped; no strobe, no error.
  - bit_cnt == FRAME_W, read: no register change.
  - bit_cnt ≠ FRAME_W (short, long, or zero bits): no change; frame_err = 1 for one clk.
- Outputs at COMMIT/IDLE:
  - CIPO_oe and CIPO return to 0 on COMMIT.
  - CIPO is 0 whenever CIPO_oe = 0.
- Latency: register update and wr_strobe occur on the 4th clk rising edge after the nCS pin rises (3 sync/detect stages + commit).
- Simultaneous events:
  - nCS fall outranks SCLK edges in the same clk.
  - nCS rise outranks SCLK edges in the same clk; those edges are discarded.
- Timing requirements:
  - f_clk ≥ 8·f_SCLK.
  - nCS high ≥ 6 clk between frames.
  - nCS fall to first SCLK rise ≥ 4 clk.
- Write strobe is not asserted for reads or errors.

Test Plan:
- Defaults, write frame 0x80F0 → regs_out[7:0] = 0xF0. wr_strobe pulses once with wr_addr = 0 on the 4th clk after nCS rise. Other registers stay 0.
- Write 0x84A5, then read frame 0x04 + 8 dummy bits → CIPO sampled on SCLK rises 9..16 = 1,0,1,0,0,1,0,1. CIPO_oe high only during data phase. No wr_strobe. reg4 is still 0xA5.
- 12-bit frame 0x81F, then a 17-bit frame → no register change. frame_err pulses once per frame. wr_strobe stays 0.
- Write to addr 0x05 (0x8533) → no change, no strobe, no error. Read of addr 0x10 → CIPO returns 0x00.
- rst_n low for 1 clk after 8 bits of a write → all outputs 0. The remainder of the frame has no effect. The next full frame 0x8155 sets reg1 = 0x55.
- Params ADDR_W=3, DATA_W=16, NUM_REGS=8, 20-bit frame writing 0xBEEF to addr 7 → regs_out[127:112] = 0xBEEF. Read-back returns 0xBEEF MSB-first.

Source files
------------

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 register bank: NUM_REGS x DATA_W registers written/read over asynchronous SPI pins.
// Latency: a write lands 4 clk after the nCS pin rises; no backpressure, the SPI controller paces frames.
module spi_regbank_peripheral #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, READOUT, COMMIT} state_t;
    state_t state, state_nxt;

    logic [2:0]         sclk_sync, ncs_sync, copi_sync;
    logic [1:0]         sync_fill;
    logic               armed;
    logic               sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_bit;

    logic [FRAME_W-1:0] rx;
    logic [DATA_W-1:0]  tx;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic [ADDR_W-1:0]  rd_addr, cm_addr;
    logic [DATA_W-1:0]  rd_word, cm_data;
    logic               cm_hit, frame_ok, do_write;

    // armed only after a genuinely sampled high nCS, so a frame cut by reset is ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            copi_sync <= '0;
            sync_fill <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SCLK};
            ncs_sync  <= {ncs_sync[1:0], nCS};
            copi_sync <= {copi_sync[1:0], COPI};
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & ncs_sync[1]);
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ncs_rise  = ncs_sync[1] & ~ncs_sync[2];
    assign ncs_fall  = ~ncs_sync[1] & ncs_sync[2];
    assign copi_bit  = copi_sync[2];
    assign busy      = ~ncs_sync[1];

    assign rd_addr  = rx[ADDR_W-1:0];
    assign cm_addr  = rx[FRAME_W-2 -: ADDR_W];
    assign cm_data  = rx[DATA_W-1:0];
    assign frame_ok = (bit_cnt == CNT_W'(FRAME_W));
    assign do_write = (state == COMMIT) && frame_ok && rx[FRAME_W-1] && cm_hit;

    always_comb begin
        rd_word = '0;
        cm_hit  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) rd_word = regs[k];
            if (cm_addr == ADDR_W'(k)) cm_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ncs_fall && armed) state_nxt = SHIFT;
            SHIFT: begin
                if (ncs_rise)
                    state_nxt = COMMIT;
                else if (bit_cnt == CNT_W'(ADDR_W + 1) && !rx[ADDR_W])
                    state_nxt = READOUT;
            end
            READOUT: if (ncs_rise) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx        <= '0;
            tx        <= '0;
            bit_cnt   <= '0;
            CIPO      <= 1'b0;
            CIPO_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= do_write;
            frame_err <= (state == COMMIT) && !frame_ok;
            if (do_write) wr_addr <= cm_addr;
            case (state)
                IDLE: begin
                    CIPO    <= 1'b0;
                    CIPO_oe <= 1'b0;
                    if (ncs_fall && armed) begin
                        bit_cnt <= '0;
                        rx      <= '0;
                        tx      <= '0;
                    end
                end
                SHIFT, READOUT: begin
                    // an nCS rise discards any SCLK edge seen in the same clk
                    if (!ncs_rise) begin
                        if (sclk_rise) begin
                            rx <= {rx[FRAME_W-2:0], copi_bit};
                            if (bit_cnt != CNT_W'(FRAME_W + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                        if (state == SHIFT && state_nxt == READOUT) tx <= rd_word;
                        if (state == READOUT && sclk_fall && bit_cnt < CNT_W'(FRAME_W)) begin
                            CIPO    <= tx[DATA_W-1];
                            tx      <= {tx[DATA_W-2:0], 1'b0};
                            CIPO_oe <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    CIPO    <= 1'b0;
                    CIPO_oe <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (do_write) begin
            for (int k = 0; k < NUM_REGS; k++)
                if (cm_addr == ADDR_W'(k)) regs[k] <= cm_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Scoreboard bench: stimulus pushes expected writes/errors/read-backs, a clk-negedge monitor pops and compares.
module tb_spi_regbank_peripheral;

    localparam int K_WR = 0, K_ERR = 1, K_RD = 2;

    typedef struct {
        int          kind;
        int          dut;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic         clk, rst_n, sclk, copi, ncs, sel;
    logic         sclk_a, ncs_a, sclk_b, ncs_b;
    logic         cipo_a, oe_a, stb_a, err_a, busy_a;
    logic         cipo_b, oe_b, stb_b, err_b, busy_b;
    logic [39:0]  regs_a;
    logic [127:0] regs_b;
    logic [6:0]   wa_a;
    logic [2:0]   wa_b;

    exp_t         q[$];
    int           checks = 0, failures = 0, cyc = 0, rise_cyc = 0, rd_n = 0;
    logic [31:0]  rd_bits = '0;
    logic         sclk_q = 1'b0, ncs_q = 1'b1;
    logic [7:0]   model_a [5];
    logic [15:0]  model_b [8];

    assign sclk_a = sel ? 1'b0 : sclk;
    assign ncs_a  = sel ? 1'b1 : ncs;
    assign sclk_b = sel ? sclk : 1'b0;
    assign ncs_b  = sel ? ncs  : 1'b1;

    spi_regbank_peripheral u_a (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk_a), .COPI(copi), .nCS(ncs_a),
        .CIPO(cipo_a), .CIPO_oe(oe_a), .regs_out(regs_a), .wr_strobe(stb_a),
        .wr_addr(wa_a), .frame_err(err_a), .busy(busy_a)
    );

    spi_regbank_peripheral #(.ADDR_W(3), .DATA_W(16), .NUM_REGS(8)) u_b (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk_b), .COPI(copi), .nCS(ncs_b),
        .CIPO(cipo_b), .CIPO_oe(oe_b), .regs_out(regs_b), .wr_strobe(stb_b),
        .wr_addr(wa_b), .frame_err(err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic expect_evt(input int kind, input int a, input int d);
        exp_t e;
        e.kind = kind;
        e.dut  = int'(sel);
        e.a    = 32'(a);
        e.d    = 32'(d);
        q.push_back(e);
    endtask

    task automatic take(input int kind, input int dut, input logic [31:0] a,
                        input logic [31:0] d, input bit chk_lat);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d dut=%0d a=%0h d=%0h, required no event",
                     kind, dut, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.dut != dut || e.a != a || e.d != d) begin
                failures++;
                $display("FAIL event: got kind=%0d dut=%0d a=%0h d=%0h, required kind=%0d dut=%0d a=%0h d=%0h",
                         kind, dut, a, d, e.kind, e.dut, e.a, e.d);
            end
        end
        if (chk_lat) begin
            checks++;
            if (cyc - rise_cyc != 4) begin
                failures++;
                $display("FAIL latency: got %0d clk after nCS rise, required 4", cyc - rise_cyc);
            end
        end
    endtask

    // Controller-side view: CIPO sampled on SCLK pin rises, frame closes on nCS pin rise
    always @(negedge clk) begin
        cyc++;
        if (sclk && !sclk_q) begin
            if (sel ? oe_b : oe_a) begin
                rd_bits = {rd_bits[30:0], (sel ? cipo_b : cipo_a)};
                rd_n++;
            end else begin
                chk("cipo_idle", 128'(sel ? cipo_b : cipo_a), 128'(0));
            end
        end
        if (ncs && !ncs_q) begin
            rise_cyc = cyc;
            if (rd_n != 0) take(K_RD, int'(sel), 32'(rd_n), rd_bits, 1'b0);
            rd_n    = 0;
            rd_bits = '0;
        end
        if (stb_a) take(K_WR, 0, 32'(wa_a), 32'(regs_a[wa_a*8 +: 8]), 1'b1);
        if (err_a) take(K_ERR, 0, 32'(0), 32'(0), 1'b1);
        if (stb_b) take(K_WR, 1, 32'(wa_b), 32'(regs_b[wa_b*16 +: 16]), 1'b1);
        if (err_b) take(K_ERR, 1, 32'(0), 32'(0), 1'b1);
        sclk_q = sclk;
        ncs_q  = ncs;
    end

    task automatic clear_models();
        for (int k = 0; k < 5; k++) model_a[k] = '0;
        for (int k = 0; k < 8; k++) model_b[k] = '0;
    endtask

    task automatic chk_idle();
        chk("rst_regs_a", 128'(regs_a), 128'(0));
        chk("rst_regs_b", regs_b, 128'(0));
        chk("rst_ctl_a", 128'({wa_a, cipo_a, oe_a, stb_a, err_a, busy_a}), 128'(0));
        chk("rst_ctl_b", 128'({wa_b, cipo_b, oe_b, stb_b, err_b, busy_b}), 128'(0));
    endtask

    task automatic chk_bank();
        logic [39:0]  ea;
        logic [127:0] eb;
        for (int k = 0; k < 5; k++) ea[k*8 +: 8] = model_a[k];
        for (int k = 0; k < 8; k++) eb[k*16 +: 16] = model_b[k];
        chk("bank_a", 128'(regs_a), 128'(ea));
        chk("bank_b", regs_b, eb);
    endtask

    // n bits MSB first; rst_after >= 0 pulses rst_n for one clk before that bit
    task automatic send(input int n, input logic [31:0] bits, input int rst_after);
        ncs = 1'b0;
        tick(6);
        for (int i = 0; i < n; i++) begin
            if (i == rst_after) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
                clear_models();
                chk_idle();
            end
            copi = bits[n-1-i];
            tick(8);
            sclk = 1'b1;
            tick(8);
            sclk = 1'b0;
        end
        tick(4);
        ncs = 1'b1;
        copi = 1'b0;
        tick(14);
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1; sel = 1'b0;
        clear_models();
        tick(4);
        rst_n = 1'b1;
        tick(2);
        chk_idle();

        expect_evt(K_WR, 0, 'hF0);  model_a[0] = 8'hF0;
        send(16, 32'h80F0, -1);
        chk_bank();

        expect_evt(K_WR, 4, 'hA5);  model_a[4] = 8'hA5;
        send(16, 32'h84A5, -1);
        expect_evt(K_RD, 8, 'hA5);
        send(16, 32'h0400, -1);
        expect_evt(K_RD, 8, 'hF0);
        send(16, 32'h0000, -1);
        chk_bank();

        expect_evt(K_ERR, 0, 0);
        send(12, 32'h81F, -1);
        expect_evt(K_ERR, 0, 0);
        send(17, 32'h101F5, -1);
        expect_evt(K_ERR, 0, 0);
        send(0, 32'h0, -1);
        chk_bank();

        send(16, 32'h8533, -1);
        expect_evt(K_RD, 8, 'h00);
        send(16, 32'h1000, -1);
        chk_bank();

        send(16, 32'h8277, 8);
        chk_bank();
        expect_evt(K_WR, 1, 'h55);  model_a[1] = 8'h55;
        send(16, 32'h8155, -1);
        chk_bank();

        sel = 1'b1;
        tick(4);
        expect_evt(K_WR, 7, 'hBEEF);  model_b[7] = 16'hBEEF;
        send(20, 32'hFBEEF, -1);
        expect_evt(K_RD, 16, 'hBEEF);
        send(20, 32'h70000, -1);
        chk_bank();

        tick(20);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d still queued, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
